// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide engine:
// FSM state and operation encodings plus default widths.
package mult_div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mult_div_if.sv
// Start/ready handshake between the control unit (master) and the
// multiply/divide engine (slave).
interface mult_div_if import mult_div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             ready;
  logic             div_zero;

  modport master (
    output mult_start, div_start, a, b,
    input  hi, lo, busy, ready, div_zero
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi, lo, busy, ready, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine working on
// operand magnitudes for WIDTH cycles, followed by one sign-fixup cycle.
module mult_div_unit import mult_div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic      Clk,
  input  logic      Reset,
  mult_div_if.slave bus
);

  state_t               state_r;
  state_t               state_next_s;
  op_t                  op_r;
  logic                 sign_a_r;
  logic                 sign_b_r;
  logic [WIDTH-1:0]     mag_b_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   acc_step_s;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic [WIDTH-1:0]     hi_fix_s;
  logic [WIDTH-1:0]     lo_fix_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       trial_s;
  logic                 busy_r;
  logic                 ready_r;
  logic                 div_zero_r;
  logic                 start_mult_s;
  logic                 start_div_s;
  logic                 div_by_zero_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v);
    neg_d = ~v + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    abs_w = v[WIDTH-1] ? neg_w(v) : v;
  endfunction

  // Multiply has priority when both starts arrive together
  assign start_mult_s  = (state_r == S_IDLE) && bus.mult_start;
  assign start_div_s   = (state_r == S_IDLE) && !bus.mult_start && bus.div_start;
  assign div_by_zero_s = start_div_s && (bus.b == {WIDTH{1'b0}});

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_mult_s || (start_div_s && !div_by_zero_s)) begin
          state_next_s = S_CALC;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_CALC;
        end
      end
      S_FIX:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // One radix-2 step; the remainder trial uses WIDTH+1 bits so the shifted-out bit is kept
  always_comb begin
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_r};
    trial_s    = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_r};
    acc_step_s = acc_r;
    if (op_r == OP_MULT) begin
      if (acc_r[0]) begin
        acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
      end else begin
        acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
      end
    end else begin
      if (!trial_s[WIDTH]) begin
        acc_step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fixup: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    hi_fix_s = acc_r[2*WIDTH-1:WIDTH];
    lo_fix_s = acc_r[WIDTH-1:0];
    if (op_r == OP_MULT) begin
      if (sign_a_r ^ sign_b_r) begin
        {hi_fix_s, lo_fix_s} = neg_d(acc_r);
      end else begin
        {hi_fix_s, lo_fix_s} = acc_r;
      end
    end else begin
      lo_fix_s = (sign_a_r ^ sign_b_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      hi_fix_s = sign_a_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_r       <= OP_MULT;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      mag_b_r    <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      ready_r    <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (div_by_zero_s) begin
            ready_r    <= 1'b1;
            div_zero_r <= 1'b1;
            busy_r     <= 1'b0;
          end else if (start_mult_s || start_div_s) begin
            op_r     <= start_mult_s ? OP_MULT : OP_DIV;
            sign_a_r <= bus.a[WIDTH-1];
            sign_b_r <= bus.b[WIDTH-1];
            mag_b_r  <= abs_w(bus.b);
            acc_r    <= {{WIDTH{1'b0}}, abs_w(bus.a)};
            cnt_r    <= CNT_W'(WIDTH);
            busy_r   <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_CALC: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        S_FIX: begin
          hi_r    <= hi_fix_s;
          lo_r    <= lo_fix_s;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.ready    = ready_r;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and model-checked bench for mult_div_unit: latency, handshake,
// corner operands, start arbitration, async reset and a random regression.
module tb_mult_div_unit;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_miss;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns negedges waited until ready is seen
  task automatic wait_ready(output int cyc, output logic gap);
    cyc = 0;
    gap = 1'b0;
    while (!bus.ready && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (!bus.ready && !bus.busy) gap = 1'b1;
    end
  endtask

  // mode 0 = mult, 1 = div, 2 = both starts together
  task automatic run_op(input int mode, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz, input string tag);
    int   cyc;
    logic gap;
    @(negedge Clk);
    bus.mult_start = (mode != 1);
    bus.div_start  = (mode != 0);
    bus.a = op_a;
    bus.b = op_b;
    @(negedge Clk);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    check_val({tag, ".busy0"}, 64'(bus.busy), exp_dz ? 64'd0 : 64'd1);
    wait_ready(cyc, gap);
    check_val({tag, ".lat"}, 64'(cyc), exp_dz ? 64'd0 : 64'd33);
    if (!exp_dz) check_val({tag, ".gap"}, 64'(gap), 64'd0);
    check_val({tag, ".hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    check_val({tag, ".dz"}, 64'(bus.div_zero), 64'(exp_dz));
    check_val({tag, ".busyr"}, 64'(bus.busy), 64'd0);
    @(negedge Clk);
    check_val({tag, ".pulse"}, {62'd0, bus.ready, bus.div_zero}, 64'd0);
    if (!exp_dz) begin
      last_hi = exp_hi;
      last_lo = exp_lo;
    end
  endtask

  task automatic model(input int mode, input logic [31:0] op_a, input logic [31:0] op_b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(op_a));
    sb = longint'($signed(op_b));
    e_dz = 1'b0;
    if (mode == 0) begin
      r = sa * sb;
      e_hi = r[63:32];
      e_lo = r[31:0];
    end else if (op_b == 32'd0) begin
      e_dz = 1'b1;
      e_hi = last_hi;
      e_lo = last_lo;
    end else begin
      r = sa / sb;
      e_lo = r[31:0];
      r = sa % sb;
      e_hi = r[31:0];
    end
  endtask

  initial begin
    int          cyc;
    logic        gap;
    int          seen;
    int          mode;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;

    n_vec = 0;
    n_miss = 0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    Reset = 1'b0;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    #12;
    check_val("rst.hilo", {bus.hi, bus.lo}, 64'd0);
    check_val("rst.flags", {61'd0, bus.busy, bus.ready, bus.div_zero}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_val("rst.rel", {61'd0, bus.busy, bus.ready, bus.div_zero}, 64'd0);

    run_op(0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mul7x-3");
    run_op(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div-7/2");
    run_op(1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, "div5/0");
    run_op(0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "minxmin");
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "min/-1");
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "m1xm1");
    run_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, "maxxmax");
    run_op(0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, "mulshift");
    run_op(1, 32'd0, 32'hFFFFFFFB, 32'd0, 32'd0, 1'b0, "div0/x");
    run_op(1, 32'd3, 32'hFFFFFFF6, 32'd3, 32'd0, 1'b0, "div3/-10");
    run_op(1, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD, 32'd0, 1'b0, "div-3/10");
    run_op(1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div100/7");
    run_op(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, "div-100/7");
    run_op(2, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "both");

    // Second start while busy is dropped
    @(negedge Clk);
    bus.mult_start = 1'b1; bus.a = 32'd6; bus.b = 32'd7;
    @(negedge Clk);
    bus.mult_start = 1'b0;
    repeat (5) @(negedge Clk);
    bus.div_start = 1'b1; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge Clk);
    bus.div_start = 1'b0;
    wait_ready(cyc, gap);
    check_val("busystart.lat", 64'(cyc), 64'd27);
    check_val("busystart.hilo", {bus.hi, bus.lo}, {32'd0, 32'd42});
    seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.ready) seen++;
    end
    check_val("busystart.extra", 64'(seen), 64'd0);

    // Start accepted in the ready cycle
    @(negedge Clk);
    bus.mult_start = 1'b1; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge Clk);
    bus.mult_start = 1'b0;
    wait_ready(cyc, gap);
    check_val("rdystart.first", {bus.hi, bus.lo}, {32'd0, 32'd12});
    bus.mult_start = 1'b1; bus.a = 32'hFFFFFFFE; bus.b = 32'd3;
    @(negedge Clk);
    bus.mult_start = 1'b0;
    check_val("rdystart.busy", 64'(bus.busy), 64'd1);
    wait_ready(cyc, gap);
    check_val("rdystart.lat", 64'(cyc), 64'd33);
    check_val("rdystart.hilo", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
    @(negedge Clk);

    // Async reset in the middle of a divide
    @(negedge Clk);
    bus.div_start = 1'b1; bus.a = 32'hFFFFFF9C; bus.b = 32'd7;
    @(negedge Clk);
    bus.div_start = 1'b0;
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check_val("arst.hilo", {bus.hi, bus.lo}, 64'd0);
    check_val("arst.flags", {61'd0, bus.busy, bus.ready, bus.div_zero}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;
    seen = 0;
    repeat (50) begin
      @(negedge Clk);
      if (bus.ready || bus.busy) seen++;
    end
    check_val("arst.stray", 64'(seen), 64'd0);
    run_op(1, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1, "arst.dz");

    // Random signed regression against a 64-bit reference model
    for (int i = 0; i < 1000; i++) begin
      mode = int'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(mode, ra, rb, ehi, elo, edz);
      run_op(mode, ra, rb, ehi, elo, edz, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
